// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with sign fix-up and registered single-cycle done pulse.
module mul_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                rsign_q, rsign_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next;
    logic [XLEN:0]       rem_sh;
    logic [XLEN+1:0]     trial;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;

    // Operand decode; MUL and the unsigned ops keep raw operands.
    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && a[XLEN-1];
        b_neg    = b_signed && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = funct3[2] && (b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (a == MinNeg) && (b == '1);
        if (div_zero) begin
            special_res = funct3[1] ? a : '1;
        end else begin
            special_res = funct3[1] ? '0 : a;
        end
    end

    // One iteration of each datapath; acc holds {hi,lo} product or {rem,quot}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        trial    = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (!trial[XLEN+1]) begin
            div_next = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = rsign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quot_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rsign_d  = rsign_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_d    = funct3;
                        neg_d   = a_neg ^ b_neg;
                        rsign_d = a_neg;
                        opnd_d  = funct3[2] ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                        cnt_d   = '0;
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = StDone;
                        end else begin
                            state_d  = StRun;
                        end
                    end
                end
                StRun: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    result_d = fix_res;
                    state_d  = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rsign_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rsign_q  <= rsign_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule
